decode_scoreboard: RTL

Issue controller between the instruction decoder and the execute stage of the pipelined processor. Keeps a per-register count of in-flight writes: a write is counted when the instruction issues and released when it writes back or is squashed. Holds decode (id_ready low) on any read-after-write hazard against an unretired write. Also sequences HALT: stops issue, drains the pipeline, then asserts halted.

---
 rtl/decode_scoreboard_pkg.sv | 19 +
 rtl/decode_scoreboard_sb_counter.sv | 46 ++++
 rtl/decode_scoreboard.sv | 107 ++++++++++
 3 files changed

// File: rtl/decode_scoreboard_pkg.sv
// Shared parameters and FSM encoding for the decode scoreboard.
package decode_scoreboard_pkg;

   localparam int unsigned NREG     = 8;
   localparam int unsigned REG_W    = 3;
   localparam int unsigned MAX_PEND = 3;
   localparam int unsigned CNT_W    = 2;

   // Link register written by JAL/JALR.
   localparam logic [REG_W-1:0] R7 = 3'd7;

   typedef enum logic [1:0] {
      StRun    = 2'd0,
      StStall  = 2'd1,
      StDrain  = 2'd2,
      StHalted = 2'd3
   } sb_state_e;

endpackage

// File: rtl/decode_scoreboard_sb_counter.sv
// One register's in-flight write counter: +1 on issue, -1 per retire/squash, floors at zero.
module sb_counter
   import decode_scoreboard_pkg::*;
(
   input  logic clk,
   input  logic rst_n,
   input  logic inc,
   input  logic dec_a,
   input  logic dec_b,
   output logic full,
   output logic nonzero,
   output logic underflow
);

   localparam logic [CNT_W:0] MaxPend = (CNT_W+1)'(MAX_PEND);

   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic [CNT_W:0]   up, down, diff;

   always_comb begin
      up        = {1'b0, cnt_q} + {{CNT_W{1'b0}}, inc};
      down      = {{CNT_W{1'b0}}, dec_a} + {{CNT_W{1'b0}}, dec_b};
      diff      = up - down;
      underflow = up < down;
      cnt_d     = cnt_q;
      if (underflow) begin
         cnt_d = '0;
      end else if (diff > MaxPend) begin
         cnt_d = MaxPend[CNT_W-1:0];
      end else begin
         cnt_d = diff[CNT_W-1:0];
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

   assign full    = (cnt_q == MaxPend[CNT_W-1:0]);
   assign nonzero = |cnt_q;

endmodule

// File: rtl/decode_scoreboard.sv
// Issue controller: per-register pending-write scoreboard, RAW/overflow stall and HALT drain.
module decode_scoreboard
   import decode_scoreboard_pkg::*;
(
   input  logic             clk,
   input  logic             rst_n,
   input  logic             id_valid,
   output logic             id_ready,
   input  logic [REG_W-1:0] id_rs1,
   input  logic [REG_W-1:0] id_rs2,
   input  logic             id_rs1_use,
   input  logic             id_rs2_use,
   input  logic [REG_W-1:0] id_rd,
   input  logic             id_rd_we,
   input  logic             id_halt,
   input  logic             wb_valid,
   input  logic [REG_W-1:0] wb_rd,
   input  logic             kill_valid,
   input  logic [REG_W-1:0] kill_rd,
   output logic             stalled,
   output logic             halted,
   output logic             sb_err,
   output logic [15:0]      stall_cycles
);

   logic [NREG-1:0] inc, dec_a, dec_b, full, nonzero, underflow;
   sb_state_e       state_q, state_d;
   logic            sb_err_q, sb_err_d;
   logic [15:0]     stall_q, stall_d;
   logic            rd_we_eff, hazard, active, issue;

   // HALT never allocates a destination, whatever the decoder says about id_rd_we.
   assign rd_we_eff = id_rd_we & ~id_halt;
   assign hazard    = (id_rs1_use & nonzero[id_rs1]) |
                      (id_rs2_use & nonzero[id_rs2]) |
                      (rd_we_eff & full[id_rd]);
   assign active    = (state_q == StRun) | (state_q == StStall);
   assign id_ready  = rst_n & active & ~hazard;
   assign issue     = id_valid & id_ready;

   for (genvar r = 0; r < NREG; r++) begin : g_cnt
      assign inc[r]   = issue & rd_we_eff & (id_rd == REG_W'(r));
      assign dec_a[r] = wb_valid & (wb_rd == REG_W'(r));
      assign dec_b[r] = kill_valid & (kill_rd == REG_W'(r));

      sb_counter u_cnt (
         .clk       (clk),
         .rst_n     (rst_n),
         .inc       (inc[r]),
         .dec_a     (dec_a[r]),
         .dec_b     (dec_b[r]),
         .full      (full[r]),
         .nonzero   (nonzero[r]),
         .underflow (underflow[r])
      );
   end

   always_comb begin
      state_d = state_q;
      unique case (state_q)
         StRun: begin
            if (issue & id_halt) begin
               state_d = StDrain;
            end else if (id_valid & hazard) begin
               state_d = StStall;
            end
         end
         StStall: begin
            if (issue & id_halt) begin
               state_d = StDrain;
            end else if (~hazard | ~id_valid) begin
               state_d = StRun;
            end
         end
         // Registered counts: halted follows the edge that emptied the last counter.
         StDrain:  if (~|nonzero) state_d = StHalted;
         StHalted: state_d = StHalted;
         default:  state_d = StRun;
      endcase
   end

   always_comb begin
      sb_err_d = sb_err_q | (|underflow);
      stall_d  = stall_q;
      if (id_valid & ~id_ready & active & ~(&stall_q)) begin
         stall_d = stall_q + 16'd1;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q  <= StRun;
         sb_err_q <= 1'b0;
         stall_q  <= '0;
      end else begin
         state_q  <= state_d;
         sb_err_q <= sb_err_d;
         stall_q  <= stall_d;
      end
   end

   assign stalled      = (state_q == StStall);
   assign halted       = (state_q == StHalted);
   assign sb_err       = sb_err_q;
   assign stall_cycles = stall_q;

endmodule
